// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with EX/MEM and MEM/WB forwarding
//               and load-use stall detection, feeding the ALU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int         DW      = 32,
  parameter int         AW      = 5,
  parameter logic [3:0] NOP_SEL = 4'b1111
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic [AW-1:0] in_rs_addr,
  input  logic [AW-1:0] in_rt_addr,
  input  logic [AW-1:0] in_rd_addr,
  input  logic [3:0]    in_sel,
  input  logic [4:0]    in_shamt,
  input  logic          in_reg_write,
  input  logic          in_mem_read,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] data_1,
  output logic [DW-1:0] data_2,
  output logic [3:0]    sel,
  output logic [4:0]    shamt,
  output logic          ex_valid,
  output logic [AW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          load_use_stall
);

  logic          r_valid;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [AW-1:0] r_rs_addr;
  logic [AW-1:0] r_rt_addr;
  logic [AW-1:0] r_rd;
  logic [3:0]    r_sel;
  logic [4:0]    r_shamt;
  logic          r_reg_write;
  logic          r_mem_read;

  logic          w_bubble;

  // A load in EX cannot supply its data in time for a dependent instruction in decode.
  assign load_use_stall = in_valid & r_valid & r_mem_read & (r_rd != '0) &
                          ((r_rd == in_rs_addr) | (r_rd == in_rt_addr));

  assign w_bubble = flush | load_use_stall | ~in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd        <= '0;
      r_sel       <= NOP_SEL;
      r_shamt     <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_sel       <= NOP_SEL;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else begin
      r_valid     <= 1'b1;
      r_rs_data   <= in_rs_data;
      r_rt_data   <= in_rt_data;
      r_rs_addr   <= in_rs_addr;
      r_rt_addr   <= in_rt_addr;
      r_rd        <= in_rd_addr;
      r_sel       <= in_sel;
      r_shamt     <= in_shamt;
      r_reg_write <= in_reg_write;
      r_mem_read  <= in_mem_read;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB; $0 is never forwarded.
  always_comb begin
    data_1 = r_rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs_addr))
      data_1 = exmem_data;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs_addr))
      data_1 = memwb_data;
  end

  always_comb begin
    data_2 = r_rt_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt_addr))
      data_2 = exmem_data;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt_addr))
      data_2 = memwb_data;
  end

  assign sel          = r_sel;
  assign shamt        = r_shamt;
  assign ex_valid     = r_valid;
  assign ex_rd        = r_rd;
  assign ex_reg_write = r_reg_write & r_valid;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed self-checking bench for id_ex_stage.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_rs_data;
  logic [DW-1:0] in_rt_data;
  logic [AW-1:0] in_rs_addr;
  logic [AW-1:0] in_rt_addr;
  logic [AW-1:0] in_rd_addr;
  logic [3:0]    in_sel;
  logic [4:0]    in_shamt;
  logic          in_reg_write;
  logic          in_mem_read;
  logic          flush;
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_rd;
  logic [DW-1:0] exmem_data;
  logic          memwb_reg_write;
  logic [AW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic [DW-1:0] data_1;
  logic [DW-1:0] data_2;
  logic [3:0]    sel;
  logic [4:0]    shamt;
  logic          ex_valid;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          load_use_stall;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.DW(DW), .AW(AW), .NOP_SEL(4'b1111)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_sel(in_sel), .in_shamt(in_shamt),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .data_1(data_1), .data_2(data_2), .sel(sel), .shamt(shamt),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [AW-1:0] rs_a, input logic [AW-1:0] rt_a,
                       input logic [AW-1:0] rd, input logic [DW-1:0] rs_d,
                       input logic [DW-1:0] rt_d, input logic [3:0] s,
                       input logic [4:0] sh, input logic rw, input logic mr);
    in_valid     = v;
    in_rs_addr   = rs_a;
    in_rt_addr   = rt_a;
    in_rd_addr   = rd;
    in_rs_data   = rs_d;
    in_rt_data   = rt_d;
    in_sel       = s;
    in_shamt     = sh;
    in_reg_write = rw;
    in_mem_read  = mr;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0;
    exmem_rd        = '0;
    exmem_data      = '0;
    memwb_reg_write = 1'b0;
    memwb_rd        = '0;
    memwb_data      = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0, 4'h0, 5'd0, 1'b0, 1'b0);
    flush = 1'b0;
    clear_fwd();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    n_cmp++; if (sel !== 4'hF) begin n_err++; $display("FAIL reset_sel: got %h want f", sel); end
    n_cmp++; if (shamt !== 5'd0) begin n_err++; $display("FAIL reset_shamt: got %0d want 0", shamt); end
    n_cmp++; if (ex_rd !== 5'd0) begin n_err++; $display("FAIL reset_ex_rd: got %0d want 0", ex_rd); end
    n_cmp++; if (ex_reg_write !== 1'b0) begin n_err++; $display("FAIL reset_reg_write: got %b want 0", ex_reg_write); end
    n_cmp++; if (data_1 !== 32'h0) begin n_err++; $display("FAIL reset_data_1: got %h want 0", data_1); end
    n_cmp++; if (data_2 !== 32'h0) begin n_err++; $display("FAIL reset_data_2: got %h want 0", data_2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (data_1 !== 32'd5) begin n_err++; $display("FAIL cap_data_1: got %h want 5", data_1); end
    n_cmp++; if (data_2 !== 32'd7) begin n_err++; $display("FAIL cap_data_2: got %h want 7", data_2); end
    n_cmp++; if (sel !== 4'b0010) begin n_err++; $display("FAIL cap_sel: got %h want 2", sel); end
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL cap_ex_valid: got %b want 1", ex_valid); end
    n_cmp++; if (shamt !== 5'd3) begin n_err++; $display("FAIL cap_shamt: got %0d want 3", shamt); end
    n_cmp++; if (ex_rd !== 5'd4) begin n_err++; $display("FAIL cap_ex_rd: got %0d want 4", ex_rd); end
    n_cmp++; if (ex_reg_write !== 1'b1) begin n_err++; $display("FAIL cap_reg_write: got %b want 1", ex_reg_write); end
    // Asynchronous reset in the middle of the cycle.
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_ex_valid: got %b want 0", ex_valid); end
    n_cmp++; if (sel !== 4'hF) begin n_err++; $display("FAIL async_rst_sel: got %h want f", sel); end
    n_cmp++; if (data_1 !== 32'h0) begin n_err++; $display("FAIL async_rst_data_1: got %h want 0", data_1); end
    n_cmp++; if (ex_reg_write !== 1'b0) begin n_err++; $display("FAIL async_rst_reg_write: got %b want 0", ex_reg_write); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, '0, '0, 4'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd5, 5'd6, 32'h11, 32'h22, 4'b0010, 5'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hAAAA0000;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_data = 32'h12345678;
    #1;
    n_cmp++; if (data_1 !== 32'hAAAA0000) begin n_err++; $display("FAIL fwd_exmem_prio: got %h want aaaa0000", data_1); end
    n_cmp++; if (data_2 !== 32'h22) begin n_err++; $display("FAIL fwd_rt_untouched: got %h want 22", data_2); end
    exmem_reg_write = 1'b0;
    #1;
    n_cmp++; if (data_1 !== 32'h12345678) begin n_err++; $display("FAIL fwd_memwb: got %h want 12345678", data_1); end
    memwb_rd = 5'd5;
    #1;
    n_cmp++; if (data_1 !== 32'h11) begin n_err++; $display("FAIL fwd_rs_none: got %h want 11", data_1); end
    n_cmp++; if (data_2 !== 32'h12345678) begin n_err++; $display("FAIL fwd_rt_memwb: got %h want 12345678", data_2); end
    exmem_reg_write = 1'b1; exmem_rd = 5'd5;
    #1;
    n_cmp++; if (data_2 !== 32'hAAAA0000) begin n_err++; $display("FAIL fwd_rt_exmem: got %h want aaaa0000", data_2); end
    clear_fwd();
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h99, 4'b0010, 5'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hFFFFFFFF;
    memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_data = 32'hFFFFFFFF;
    #1;
    n_cmp++; if (data_1 !== 32'h0) begin n_err++; $display("FAIL zero_reg_rs: got %h want 0", data_1); end
    n_cmp++; if (data_2 !== 32'h99) begin n_err++; $display("FAIL zero_reg_rt: got %h want 99", data_2); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 4'b0010, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd8, 5'd9, 32'h10, 32'h20, 4'b0110, 5'd2, 1'b1, 1'b0);
    #1;
    n_cmp++; if (load_use_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", load_use_stall); end
    @(posedge clk); #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble_valid: got %b want 0", ex_valid); end
    n_cmp++; if (sel !== 4'hF) begin n_err++; $display("FAIL lu_bubble_sel: got %h want f", sel); end
    n_cmp++; if (ex_reg_write !== 1'b0) begin n_err++; $display("FAIL lu_bubble_rw: got %b want 0", ex_reg_write); end
    n_cmp++; if (load_use_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_release: got %b want 0", load_use_stall); end
    @(posedge clk); #1;
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL lu_retry_valid: got %b want 1", ex_valid); end
    n_cmp++; if (sel !== 4'b0110) begin n_err++; $display("FAIL lu_retry_sel: got %h want 6", sel); end
    n_cmp++; if (ex_rd !== 5'd9) begin n_err++; $display("FAIL lu_retry_rd: got %0d want 9", ex_rd); end
    n_cmp++; if (data_2 !== 32'h20) begin n_err++; $display("FAIL lu_retry_data_2: got %h want 20", data_2); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 4'b0010, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd8, 5'd2, 5'd9, 32'h10, 32'h20, 4'b0110, 5'd0, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_cmp++; if (load_use_stall !== 1'b1) begin n_err++; $display("FAIL fl_stall_seen: got %b want 1", load_use_stall); end
    @(posedge clk); #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %b want 0", ex_valid); end
    n_cmp++; if (ex_reg_write !== 1'b0) begin n_err++; $display("FAIL fl_reg_write: got %b want 0", ex_reg_write); end
    n_cmp++; if (sel !== 4'hF) begin n_err++; $display("FAIL fl_sel: got %h want f", sel); end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b1, 5'd2, 5'd3, 5'd10, 32'h30, 32'h40, 4'b0001, 5'd7, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL fl_next_valid: got %b want 1", ex_valid); end
    n_cmp++; if (sel !== 4'b0001) begin n_err++; $display("FAIL fl_next_sel: got %h want 1", sel); end
    n_cmp++; if (ex_rd !== 5'd10) begin n_err++; $display("FAIL fl_next_rd: got %0d want 10", ex_rd); end
    n_cmp++; if (data_1 !== 32'h30) begin n_err++; $display("FAIL fl_next_data_1: got %h want 30", data_1); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]    sels [4] = '{4'h3, 4'h4, 4'h5, 4'h7};
    logic [4:0]    shs  [4] = '{5'd1, 5'd2, 5'd17, 5'd31};
    logic [AW-1:0] rds  [4] = '{5'd11, 5'd12, 5'd13, 5'd14};
    logic          rws  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd20, 5'd21, rds[i], 32'h100 + i, 32'h200 + i, sels[i], shs[i], rws[i], 1'b0);
      @(posedge clk); #1;
      n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, ex_valid); end
      n_cmp++; if (sel !== sels[i]) begin n_err++; $display("FAIL b2b_sel[%0d]: got %h want %h", i, sel, sels[i]); end
      n_cmp++; if (shamt !== shs[i]) begin n_err++; $display("FAIL b2b_shamt[%0d]: got %0d want %0d", i, shamt, shs[i]); end
      n_cmp++; if (ex_rd !== rds[i]) begin n_err++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i, ex_rd, rds[i]); end
      n_cmp++; if (ex_reg_write !== rws[i]) begin n_err++; $display("FAIL b2b_rw[%0d]: got %b want %b", i, ex_reg_write, rws[i]); end
    end
    @(negedge clk);
    drive(1'b0, '0, '0, '0, '0, '0, 4'h0, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_valid: got %b want 0", ex_valid); end
    n_cmp++; if (sel !== 4'hF) begin n_err++; $display("FAIL b2b_idle_sel: got %h want f", sel); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_forward();
    test_zero_reg();
    test_load_use();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded operands and control from decode, and presents ALU inputs data_1, data_2, sel and shamt in the EX stage.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and requests a one-cycle stall of decode.

Parameters:
- DW, 32, operand/result width.
- AW, 5, register address width.
- NOP_SEL, 4'b1111, ALU select driven for a bubble.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode presents a valid instruction
- in_rs_data  input  DW  register-file rs read value
- in_rt_data  input  DW  register-file rt read value
- in_rs_addr  input  AW  rs index
- in_rt_addr  input  AW  rt index
- in_rd_addr  input  AW  destination index
- in_sel  input  4  ALU select
- in_shamt  input  5  shift amount
- in_reg_write  input  1  instruction writes rd
- in_mem_read  input  1  instruction is a load
- flush  input  1  insert bubble (branch taken)
- exmem_reg_write  input  1  EX/MEM writes back
- exmem_rd  input  AW  EX/MEM destination
- exmem_data  input  DW  EX/MEM ALU result
- memwb_reg_write  input  1  MEM/WB writes back
- memwb_rd  input  AW  MEM/WB destination
- memwb_data  input  DW  MEM/WB write-back value
- data_1  output  DW  ALU operand 1 (forwarded rs)
- data_2  output  DW  ALU operand 2 (forwarded rt)
- sel  output  4  ALU select
- shamt  output  5  ALU shift amount
- ex_valid  output  1  EX stage holds a real instruction
- ex_rd  output  AW  destination carried to EX/MEM
- ex_reg_write  output  1  write enable carried to EX/MEM (0 when invalid)
- load_use_stall  output  1  decode must hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_n=0, async):
  - All stage registers clear: ex_valid=0, sel=NOP_SEL, shamt=0, ex_rd=0, ex_reg_write=0, stored rs/rt data=0, stored addrs=0, ex_mem_read=0.
  - data_1 and data_2 read 0.
  - Reset mid-stream discards the in-flight instruction; no partial state survives.
- Load-use detection, combinational:
  - load_use_stall = in_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==in_rs_addr | ex_rd==in_rt_addr).
- Register update at each posedge clk, evaluated in priority order:
  1. flush=1: load a bubble. ex_valid=0, sel=NOP_SEL, ex_reg_write=0, ex_mem_read=0. Flush beats the stall.
  2. load_use_stall=1: load a bubble (same values as flush). Decode holds its instruction and re-presents it next cycle.
  3. in_valid=1: capture all in_* fields; ex_valid=1.
  4. Otherwise: load a bubble.
- Latency:
  - Exactly one cycle from capture to appearance on the ALU-facing outputs.
  - A stalled instruction enters EX one cycle late; no instruction is ever duplicated or dropped.
- Forwarding, combinational on the registered fields:
  - rs path: if exmem_reg_write & exmem_rd!=0 & exmem_rd==stored rs addr, data_1=exmem_data. Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs addr, data_1=memwb_data. Else data_1=stored rs data.
  - rt path (data_2) follows the identical rule using the rt address.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded and always reads the stored value.
- Bubble outputs:
  - When ex_valid=0: sel=NOP_SEL, ex_reg_write=0.
  - data_1/data_2 are still computed but are don't-care.
- Width rules:
  - shamt passes through unmodified.
  - No sign or zero extension is performed here; immediates arrive already extended on in_rt_data.

Test Plan:
- Reset then in_valid=1, rs_data=5, rt_data=7, sel=ADD(4'b0010) → next cycle data_1=5, data_2=7, sel=4'b0010, ex_valid=1; assert rst_n=0 mid-cycle → outputs drop to the reset values immediately.
- Stored rs addr=3; exmem_rd=3, exmem_reg_write=1, exmem_data=0xAAAA0000; memwb_rd=3, memwb_data=0x12345678 → data_1=0xAAAA0000. Deassert exmem_reg_write → data_1=0x12345678.
- exmem_rd=0, exmem_reg_write=1, exmem_data=0xFFFFFFFF, stored rs addr=0, stored rs data=0 → data_1=0 (no forward from $0).
- EX holds a load with ex_rd=8; decode presents rt_addr=8 → load_use_stall=1, next cycle ex_valid=0 and sel=4'b1111. Decode re-presents → captured with ex_valid=1 after exactly one bubble.
- flush=1 together with load_use_stall=1 and in_valid=1 → bubble inserted, ex_reg_write=0. A subsequent valid instruction is captured normally.
- Back-to-back valid instructions for 4 cycles with no hazards → each appears on sel/shamt/ex_rd one cycle after presentation, in order, with no gaps.
